// File: rtl/spi_master_ctrl.sv
// rtl/spi_master_ctrl.sv - SPI mode-0 transaction controller driving an external 8-bit shift register
// Optional sticky completion flag (irq/irq_clr) built only when SPI_CTRL_IRQ_EN is defined.
module spi_master_ctrl #(
  parameter int CLK_DIV = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] tx_data,
  output logic       busy,
  output logic       done,
  output logic [7:0] rx_data,
  output logic [7:0] sr_data,
  output logic       sr_ld,
  output logic       sr_en,
  output logic       sr_un_ld,
  input  logic [7:0] sr_data_out,
`ifdef SPI_CTRL_IRQ_EN
  output logic       irq,
  input  logic       irq_clr,
`endif
  output logic       sclk,
  output logic       cs_n
);

  if (CLK_DIV < 1) begin : g_bad_div
    $error("CLK_DIV must be >= 1");
  end

  localparam int CW = $clog2(CLK_DIV + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SETUP, S_SHIFT, S_UNLOAD, S_DONE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [2:0]    bit_cnt, bit_cnt_nxt;
  logic          sclk_nxt, sr_en_nxt;
  logic          phase_end;

  assign phase_end = (cnt == CNT_LAST);

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    bit_cnt_nxt = bit_cnt;
    sclk_nxt    = 1'b0;
    sr_en_nxt   = 1'b0;
    case (state)
      S_IDLE:   if (start && !abort) state_nxt = S_LOAD;
      S_LOAD: begin
        state_nxt   = S_SETUP;
        cnt_nxt     = '0;
        bit_cnt_nxt = '0;
      end
      S_SETUP: begin
        if (phase_end) begin
          state_nxt = S_SHIFT;
          cnt_nxt   = '0;
          sclk_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_SHIFT: begin
        sclk_nxt = sclk;
        if (phase_end) begin
          cnt_nxt = '0;
          if (sclk) begin
            sclk_nxt    = 1'b0;
            sr_en_nxt   = 1'b1;
            bit_cnt_nxt = bit_cnt + 1'b1;
          end else if (bit_cnt == 3'd0) begin
            // bit counter has wrapped after eight shifts: last low phase just ended
            state_nxt = S_UNLOAD;
            sclk_nxt  = 1'b0;
          end else begin
            sclk_nxt = 1'b1;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_UNLOAD: state_nxt = S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
    if (abort && state != S_IDLE) begin
      state_nxt = S_IDLE;
      cnt_nxt   = '0;
      sclk_nxt  = 1'b0;
      sr_en_nxt = 1'b0;
    end
  end

  // Outputs are registered from the next state so they line up with the state they describe
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      bit_cnt  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      rx_data  <= 8'h00;
      sr_data  <= 8'h00;
      sr_ld    <= 1'b0;
      sr_en    <= 1'b0;
      sr_un_ld <= 1'b0;
      sclk     <= 1'b0;
      cs_n     <= 1'b1;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      bit_cnt  <= bit_cnt_nxt;
      sclk     <= sclk_nxt;
      sr_en    <= sr_en_nxt;
      sr_ld    <= (state_nxt == S_LOAD);
      sr_un_ld <= (state_nxt == S_UNLOAD);
      done     <= (state_nxt == S_DONE);
      busy     <= (state_nxt != S_IDLE);
      cs_n     <= !(state_nxt inside {S_LOAD, S_SETUP, S_SHIFT, S_UNLOAD});
      if (state == S_IDLE && state_nxt == S_LOAD) sr_data <= tx_data;
      if (state == S_UNLOAD && state_nxt == S_DONE) rx_data <= sr_data_out;
    end
  end

`ifdef SPI_CTRL_IRQ_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         irq <= 1'b0;
    else if (done)    irq <= 1'b1;
    else if (irq_clr) irq <= 1'b0;
  end
`endif

endmodule
